// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit and the ALU control unit:
// opcodes, FSM state encoding, AluOp and datapath mux codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True when leaving this state completes an instruction and returns to FETCH.
    function automatic logic retires(input state_e s, input logic mem_ready);
        case (s)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retires = 1'b1;
            S_MEM_WRITE:                                    retires = mem_ready;
            default:                                        retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and mux selects, and counts retired instructions.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCondEq,
    output logic             PCWriteCondNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       AluOp,
    output logic [1:0]       PCSource,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    state_e           state_q, state_d;
    logic [5:0]       opcode_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= Opcode;
            end
            if (retires(state_q, MemReady)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:     state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE:       state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = MemReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCondEq = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        AluSrcA       = 1'b0;
        AluSrcB       = SRCB_RT;
        AluOp         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;
        IllegalOp     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                AluSrcB = SRCB_IMM_SH;
                case (Opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI: IllegalOp = 1'b0;
                    default:                                               IllegalOp = 1'b1;
                endcase
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                AluSrcA = 1'b1;
                AluOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA       = 1'b1;
                AluOp         = ALUOP_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCondEq = (opcode_q == OP_BEQ);
                PCWriteCondNe = (opcode_q == OP_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDI_WB:   RegWrite = 1'b1;
            default:     ;
        endcase
        // Reset holds the FSM in FETCH; the Mealy terms must not leak write strobes meanwhile.
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCondEq = 1'b0;
            PCWriteCondNe = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            IllegalOp     = 1'b0;
        end
    end

    assign InstrCount = count_q;
    assign State      = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: per-cycle vectors of inputs and expected
// state/control word/count, pushed to a scoreboard and compared before each clock edge.
module tb_main_control_fsm;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = '0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, AluSrcA, IllegalOp;
    logic [1:0] AluSrcB, AluOp, PCSource;
    logic [3:0] InstrCount;
    logic [3:0] State;

    main_control_fsm #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCondEq(PCWriteCondEq), .PCWriteCondNe(PCWriteCondNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource), .IllegalOp(IllegalOp),
        .InstrCount(InstrCount), .State(State)
    );

    always #5 clk = ~clk;

    // Control word: PCWrite,CondEq,CondNe | IorD,MemRead,MemWrite,IRWrite | MemToReg,RegDst,RegWrite | AluSrcA,AluSrcB,AluOp,PCSource,IllegalOp
    localparam logic [17:0] C_FETCH_RDY  = {1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_DEC        = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_DEC_ILL    = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [17:0] C_MADDR      = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_MREAD      = {1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_MWB        = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_MWRITE     = {1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_REXEC      = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [17:0] C_RWB        = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1, 1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_BEQ        = {1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [17:0] C_BNE        = {1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [17:0] C_JUMP       = {1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [17:0] C_AEXEC      = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [17:0] C_AWB        = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 1'b0,2'b00,2'b00,2'b00,1'b0};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] cw;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [3:0] exp_cnt;

    task automatic apply(input vec_t v);
        vec_t       e;
        logic [17:0] act;
        @(negedge clk);
        reset    = v.rst;
        Opcode   = v.op;
        MemReady = v.mr;
        sb.push_back(v);
        #2;
        e   = sb.pop_front();
        act = {PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource, IllegalOp};
        n_vec++;
        if (State !== e.st) begin
            n_miss++;
            $display("FAIL state vec%0d: got %0d expected %0d", n_vec, State, e.st);
        end
        if (act !== e.cw) begin
            n_miss++;
            $display("FAIL ctrl vec%0d (state %0d): got %b expected %b", n_vec, e.st, act, e.cw);
        end
        if (InstrCount !== e.cnt) begin
            n_miss++;
            $display("FAIL count vec%0d: got %0d expected %0d", n_vec, InstrCount, e.cnt);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input state_e st, input logic [17:0] cw, input logic [3:0] cnt);
        vec_t v;
        v = '{rst: r, op: op, mr: mr, st: st, cw: cw, cnt: cnt};
        apply(v);
    endtask

    initial begin
        // reset with MemReady high: Mealy write strobes still forced low
        tbl.push_back('{1'b1, OP_LW,   1'b1, S_FETCH,     C_FETCH_WAIT, 4'd0});
        // LW, opcode changed to SW in MEM_ADDR to prove the latched copy is used
        tbl.push_back('{1'b0, OP_LW,   1'b1, S_FETCH,     C_FETCH_RDY,  4'd0});
        tbl.push_back('{1'b0, OP_LW,   1'b1, S_DECODE,    C_DEC,        4'd0});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_MEM_ADDR,  C_MADDR,      4'd0});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_MEM_READ,  C_MREAD,      4'd0});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_MEM_WB,    C_MWB,        4'd0});
        // R-type
        tbl.push_back('{1'b0, OP_RTYPE,1'b1, S_FETCH,     C_FETCH_RDY,  4'd1});
        tbl.push_back('{1'b0, OP_RTYPE,1'b1, S_DECODE,    C_DEC,        4'd1});
        tbl.push_back('{1'b0, OP_RTYPE,1'b1, S_R_EXEC,    C_REXEC,      4'd1});
        tbl.push_back('{1'b0, OP_RTYPE,1'b1, S_R_WB,      C_RWB,        4'd1});
        // BNE, live opcode switched to BEQ in BRANCH
        tbl.push_back('{1'b0, OP_BNE,  1'b1, S_FETCH,     C_FETCH_RDY,  4'd2});
        tbl.push_back('{1'b0, OP_BNE,  1'b1, S_DECODE,    C_DEC,        4'd2});
        tbl.push_back('{1'b0, OP_BEQ,  1'b1, S_BRANCH,    C_BNE,        4'd2});
        // FETCH stalls 3 cycles, SW stalls 2 cycles: 9 cycles
        tbl.push_back('{1'b0, OP_SW,   1'b0, S_FETCH,     C_FETCH_WAIT, 4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b0, S_FETCH,     C_FETCH_WAIT, 4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b0, S_FETCH,     C_FETCH_WAIT, 4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_FETCH,     C_FETCH_RDY,  4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_DECODE,    C_DEC,        4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_MEM_ADDR,  C_MADDR,      4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b0, S_MEM_WRITE, C_MWRITE,     4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b0, S_MEM_WRITE, C_MWRITE,     4'd3});
        tbl.push_back('{1'b0, OP_SW,   1'b1, S_MEM_WRITE, C_MWRITE,     4'd3});
        // ADDI
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, S_FETCH,     C_FETCH_RDY,  4'd4});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, S_DECODE,    C_DEC,        4'd4});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, S_ADDI_EXEC, C_AEXEC,      4'd4});
        tbl.push_back('{1'b0, OP_ADDI, 1'b1, S_ADDI_WB,   C_AWB,        4'd4});
        // BEQ
        tbl.push_back('{1'b0, OP_BEQ,  1'b1, S_FETCH,     C_FETCH_RDY,  4'd5});
        tbl.push_back('{1'b0, OP_BEQ,  1'b1, S_DECODE,    C_DEC,        4'd5});
        tbl.push_back('{1'b0, OP_BNE,  1'b1, S_BRANCH,    C_BEQ,        4'd5});
        // illegal opcode: one-cycle pulse, back to FETCH, no retire
        tbl.push_back('{1'b0, 6'h3F,   1'b1, S_FETCH,     C_FETCH_RDY,  4'd6});
        tbl.push_back('{1'b0, 6'h3F,   1'b1, S_DECODE,    C_DEC_ILL,    4'd6});
        tbl.push_back('{1'b0, 6'h3F,   1'b0, S_FETCH,     C_FETCH_WAIT, 4'd6});

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // J instructions drive the 4-bit counter from 6 through 15 and wrap to 0
        exp_cnt = 4'd6;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, OP_J, 1'b1, S_FETCH,  C_FETCH_RDY, exp_cnt);
            step(1'b0, OP_J, 1'b1, S_DECODE, C_DEC,       exp_cnt);
            step(1'b0, OP_J, 1'b1, S_JUMP,   C_JUMP,      exp_cnt);
            exp_cnt = exp_cnt + 4'd1;
        end
        step(1'b0, OP_J, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd0);
        step(1'b0, OP_J, 1'b1, S_DECODE, C_DEC,       4'd0);
        step(1'b0, OP_J, 1'b1, S_JUMP,   C_JUMP,      4'd0);

        // LW aborted by reset while waiting in MEM_READ; reset takes effect before any clock edge
        step(1'b0, OP_LW, 1'b1, S_FETCH,    C_FETCH_RDY,  4'd1);
        step(1'b0, OP_LW, 1'b1, S_DECODE,   C_DEC,        4'd1);
        step(1'b0, OP_LW, 1'b1, S_MEM_ADDR, C_MADDR,      4'd1);
        step(1'b0, OP_LW, 1'b0, S_MEM_READ, C_MREAD,      4'd1);
        step(1'b1, OP_LW, 1'b1, S_FETCH,    C_FETCH_WAIT, 4'd0);
        step(1'b1, OP_LW, 1'b1, S_FETCH,    C_FETCH_WAIT, 4'd0);
        step(1'b0, OP_LW, 1'b0, S_FETCH,    C_FETCH_WAIT, 4'd0);
        step(1'b0, OP_LW, 1'b1, S_FETCH,    C_FETCH_RDY,  4'd0);
        step(1'b0, OP_LW, 1'b1, S_DECODE,   C_DEC,        4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode, and drives every datapath enable and mux select. It sits directly upstream of the ALU control unit, supplying the 2-bit AluOp that the ALU control unit combines with Funct. It also stalls on a memory-ready handshake and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Opcode  in  6  instruction[31:26], valid from DECODE onward
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCondEq  out  1  PC load if ALU Zero=1 (BEQ)
- PCWriteCondNe  out  1  PC load if ALU Zero=0 (BNE)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemToReg  out  1  write-back data select: 0=ALUOut, 1=MDR
- RegDst  out  1  destination select: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- AluSrcA  out  1  0=PC, 1=rs
- AluSrcB  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- AluOp  out  2  00=add, 01=sub, 10=use Funct
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- IllegalOp  out  1  one-cycle pulse on an unknown opcode
- InstrCount  out  CNT_W  retired instructions
- State  out  4  current state (debug)

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00. IRWrite and PCWrite equal MemReady. Stay in FETCH while MemReady=0. Go to DECODE when MemReady=1.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - any other opcode -> FETCH, with IllegalOp=1 for that cycle
- MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=00. LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until MemReady, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until MemReady, then -> FETCH.
- R_EXEC: AluSrcA=1, AluSrcB=00, AluOp=10 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0 -> FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCSource=01. Assert PCWriteCondEq for BEQ, PCWriteCondNe for BNE -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDI_EXEC: AluSrcA=1, AluSrcB=10, AluOp=00 -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0 -> FETCH.
- Outputs not listed for a state are 0.
- Opcode is latched at DECODE, so MEM_ADDR and BRANCH use the latched copy.
- InstrCount increments by 1 on every transition into FETCH from a final state (MEM_WB, MEM_WRITE with MemReady, R_WB, BRANCH, JUMP, ADDI_WB). It does not increment on an illegal opcode and wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous): State=FETCH, InstrCount=0, latched opcode=0. While reset=1, PCWrite, PCWriteCond*, IRWrite, RegWrite, MemWrite and IllegalOp are forced to 0.
- Other outputs are decoded combinationally from State (Moore). The exceptions are IRWrite, PCWrite in FETCH, and IllegalOp, which depend on inputs (Mealy).
- Cycles per instruction with zero wait states: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3. Each MemReady=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Reset asserted mid-instruction aborts it: no count increment and no write enable in the reset cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI)
  - the 4-bit state encoding
  - AluOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), also used by the ALU control unit
- Single module; no sub-module needed. The next-state logic and the output decode are two separate always blocks.

## Test plan
- Reset asserted mid-MEM_READ -> State=FETCH immediately, InstrCount=0, all write enables 0.
- LW (100011) with MemReady=1 always -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; AluOp sequence 00,00,00,-,-; InstrCount 0->1 after 5 cycles.
- R-type (000000) -> AluOp=10 in R_EXEC, RegWrite=1 and RegDst=1 in R_WB; 4 cycles.
- BNE (000101) -> BRANCH with AluOp=01, PCWriteCondNe=1, PCWriteCondEq=0; 3 cycles.
- FETCH with MemReady low for 3 cycles, then SW with MemReady low for 2 cycles -> IRWrite pulses only when MemReady=1; total 4+5=9 cycles.
- Opcode 111111 -> IllegalOp=1 for one cycle in DECODE, return to FETCH, InstrCount unchanged. InstrCount preloaded via repeated J instructions to 2^CNT_W−1 (use CNT_W=4) -> wraps to 0.
